stage_sequencer: RTL and testbench
==================================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'd0: PC value loaded on reset.
REQ-002 SHALL have parameter CNT_W, default 32: width of retired-instruction counter.
REQ-003 SHALL have ports: clk in 1 system clock; rst in 1 reset (one clock; reset is asynchronous and active-high).
REQ-004 SHALL have ports: start in 1 begin execution from IDLE; halt_in in 1 fetch decoded halt; imem_error in 1 fetch address error; instr_invalid in 1 fetch invalid icode; dmem_error in 1 memory stage address error.
REQ-005 SHALL have ports: pc_new in 64 next PC from pc_update; pc out 64 current PC to fetch.
REQ-006 SHALL have ports: f_en, d_en, e_en, m_en, w_en, pc_en out 1 each, stage enables; stat out 3 Y86 status; running out 1; instr_count out CNT_W retired instructions.

Function
REQ-007 SHALL implement FSM states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, STOPPED (plus PAUSE per REQ-021).
REQ-008 SHALL assert exactly one stage enable, registered, for the whole cycle in the matching state (FETCH->f_en ... PCUPD->pc_en); all enables 0 in IDLE, PAUSE, STOPPED.
REQ-009 IDLE: start=1 at a clk edge -> FETCH next cycle; start ignored in every other state.
REQ-010 Non-error path SHALL advance one state per cycle FETCH->DECODE->EXECUTE->MEMORY->WRITEBACK->PCUPD: 6 cycles per instruction.
REQ-011 At end of FETCH, error priority SHALL be imem_error > instr_invalid > halt_in; first asserted sets stat to ADR(3), INS(4) or HLT(2) respectively and goes to STOPPED.
REQ-012 At end of MEMORY, dmem_error=1 SHALL set stat=ADR(3) and go to STOPPED; WRITEBACK and PCUPD are not entered.
REQ-013 Error/halt inputs SHALL be sampled only in the state named; values in other states ignored.
REQ-014 At end of PCUPD: pc <= pc_new, instr_count <= instr_count+1 (wraps modulo 2^CNT_W to 0), stat stays AOK(1).
REQ-015 Halted or faulting instruction SHALL NOT increment instr_count or change pc; pc keeps faulting instruction address.
REQ-016 STOPPED SHALL be terminal; exit only by rst.
REQ-017 running SHALL be 1 in FETCH..PCUPD and PAUSE, 0 in IDLE and STOPPED.

Reset
REQ-018 rst=1 SHALL immediately (no clock) force state IDLE, pc=RESET_PC, stat=AOK(1), instr_count=0, all enables 0, running=0.
REQ-019 rst asserted mid-instruction SHALL abandon it: no pc update, no count increment.
REQ-020 After rst deasserts, the first clk edge with start=1 SHALL enter FETCH.

Configuration
REQ-021 Macro SEQ_STEP_EN defined: extra input port step (1 bit); PCUPD goes to PAUSE; PAUSE goes to FETCH on step=1, else holds; step ignored elsewhere.
REQ-022 SEQ_STEP_EN undefined: no step port, no PAUSE state; PCUPD goes directly to FETCH.

Verification
REQ-023 rst pulse, then start=1 one cycle, pc_new=pc+10 each PCUPD, no errors -> f_en..pc_en each high 1 cycle in order; pc 0,10,20; instr_count=3 after 18 cycles.
REQ-024 2nd FETCH with halt_in=1 -> stat=2, STOPPED, pc=10, instr_count=1, all enables 0, running=0; start=1 afterwards has no effect.
REQ-025 FETCH with imem_error=1, instr_invalid=1, halt_in=1 together -> stat=3; with only instr_invalid=1 and halt_in=1 -> stat=4.
REQ-026 dmem_error=1 in MEMORY -> stat=3, w_en and pc_en never asserted, pc and instr_count unchanged; dmem_error=1 during EXECUTE only -> ignored, normal retire.
REQ-027 rst asserted asynchronously mid-EXECUTE (between clk edges) -> outputs at reset values before next edge; pc=RESET_PC, instr_count=0.
REQ-028 SEQ_STEP_EN defined, step=0 -> after first PCUPD holds PAUSE 5 cycles, enables 0, running=1; step=1 one cycle -> FETCH next cycle.

Source files
------------

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle Y86 sequencer. It walks each instruction through
// FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD, one cycle per stage, and
// raises exactly one registered stage enable in each of those states. Faults
// seen in FETCH or MEMORY stop the machine for good; only rst leaves STOPPED.
// Optional feature: define SEQ_STEP_EN to add a `step` input and a PAUSE state
// after every PCUPD, which allows single-stepping one instruction at a time.
module stage_sequencer #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_in,
  input  logic             imem_error,
  input  logic             instr_invalid,
  input  logic             dmem_error,
`ifdef SEQ_STEP_EN
  input  logic             step,
`endif
  input  logic [63:0]      pc_new,
  output logic [63:0]      pc,
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_en,
  output logic             w_en,
  output logic             pc_en,
  output logic [2:0]       stat,
  output logic             running,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] ST_AOK = 3'd1;
  localparam logic [2:0] ST_HLT = 3'd2;
  localparam logic [2:0] ST_ADR = 3'd3;
  localparam logic [2:0] ST_INS = 3'd4;

  // One-hot stage enables, bit order f,d,e,m,w,pc from LSB.
  localparam logic [5:0] EN_F  = 6'b000001;
  localparam logic [5:0] EN_D  = 6'b000010;
  localparam logic [5:0] EN_E  = 6'b000100;
  localparam logic [5:0] EN_M  = 6'b001000;
  localparam logic [5:0] EN_W  = 6'b010000;
  localparam logic [5:0] EN_PC = 6'b100000;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD,
    S_STOPPED
`ifdef SEQ_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  state_t     state;
  logic [5:0] en_q;
  logic [2:0] fetch_fault;

  assign f_en  = en_q[0];
  assign d_en  = en_q[1];
  assign e_en  = en_q[2];
  assign m_en  = en_q[3];
  assign w_en  = en_q[4];
  assign pc_en = en_q[5];

  // Fetch fault status with imem_error > instr_invalid > halt_in; 0 means none.
  always_comb begin
    fetch_fault = 3'd0;
    if (imem_error)         fetch_fault = ST_ADR;
    else if (instr_invalid) fetch_fault = ST_INS;
    else if (halt_in)       fetch_fault = ST_HLT;
  end

  // Sequencer FSM; enables and running are loaded together with the next state
  // so they are registered and valid for the whole cycle of that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      stat        <= ST_AOK;
      instr_count <= '0;
      en_q        <= '0;
      running     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_FETCH;
            en_q    <= EN_F;
            running <= 1'b1;
          end
        end
        S_FETCH: begin
          if (fetch_fault != 3'd0) begin
            // pc stays on the faulting instruction, count untouched
            state   <= S_STOPPED;
            stat    <= fetch_fault;
            en_q    <= '0;
            running <= 1'b0;
          end else begin
            state <= S_DECODE;
            en_q  <= EN_D;
          end
        end
        S_DECODE: begin
          state <= S_EXECUTE;
          en_q  <= EN_E;
        end
        S_EXECUTE: begin
          state <= S_MEMORY;
          en_q  <= EN_M;
        end
        S_MEMORY: begin
          if (dmem_error) begin
            state   <= S_STOPPED;
            stat    <= ST_ADR;
            en_q    <= '0;
            running <= 1'b0;
          end else begin
            state <= S_WRITEBACK;
            en_q  <= EN_W;
          end
        end
        S_WRITEBACK: begin
          state <= S_PCUPD;
          en_q  <= EN_PC;
        end
        S_PCUPD: begin
          // retire: commit next pc and bump the counter (wraps naturally)
          pc          <= pc_new;
          instr_count <= instr_count + CNT_W'(1);
`ifdef SEQ_STEP_EN
          state <= S_PAUSE;
          en_q  <= '0;
`else
          state <= S_FETCH;
          en_q  <= EN_F;
`endif
        end
`ifdef SEQ_STEP_EN
        S_PAUSE: begin
          if (step) begin
            state <= S_FETCH;
            en_q  <= EN_F;
          end
        end
`endif
        S_STOPPED: begin
          state <= S_STOPPED;
        end
        default: begin
          state   <= S_IDLE;
          en_q    <= '0;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed scenarios followed by randomized inputs,
// all checked every cycle against a stage-index reference model.
module tb_stage_sequencer;
  localparam int          CNT_W = 4;
  localparam logic [63:0] RPC   = 64'h100;
`ifdef SEQ_STEP_EN
  localparam int INSTR_CYC = 7;
`else
  localparam int INSTR_CYC = 6;
`endif

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, halt_in = 1'b0;
  logic imem_error = 1'b0, instr_invalid = 1'b0, dmem_error = 1'b0;
`ifdef SEQ_STEP_EN
  logic step = 1'b1;
`endif
  logic [63:0]      pc_new = '0, pc;
  logic             f_en, d_en, e_en, m_en, w_en, pc_en, running;
  logic [2:0]       stat;
  logic [CNT_W-1:0] instr_count;

  int n_vec = 0, n_miss = 0;

  // Reference model: m_ph is -1 idle, 0..5 stage of the current instruction,
  // 6 paused after retire, 7 stopped.
  int               m_ph;
  logic [63:0]      m_pc;
  logic [2:0]       m_stat;
  logic [CNT_W-1:0] m_cnt;

  stage_sequencer #(.RESET_PC(RPC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_in(halt_in),
    .imem_error(imem_error), .instr_invalid(instr_invalid),
    .dmem_error(dmem_error),
`ifdef SEQ_STEP_EN
    .step(step),
`endif
    .pc_new(pc_new), .pc(pc), .f_en(f_en), .d_en(d_en), .e_en(e_en),
    .m_en(m_en), .w_en(w_en), .pc_en(pc_en), .stat(stat), .running(running),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = -1; m_pc = RPC; m_stat = 3'd1; m_cnt = '0;
  endtask

  task automatic model_edge();
    case (m_ph)
      -1: if (start) m_ph = 0;
      0: begin
        if (imem_error)         begin m_stat = 3'd3; m_ph = 7; end
        else if (instr_invalid) begin m_stat = 3'd4; m_ph = 7; end
        else if (halt_in)       begin m_stat = 3'd2; m_ph = 7; end
        else m_ph = 1;
      end
      3: begin
        if (dmem_error) begin m_stat = 3'd3; m_ph = 7; end
        else m_ph = 4;
      end
      5: begin
        m_pc  = pc_new;
        m_cnt = m_cnt + 1'b1;
`ifdef SEQ_STEP_EN
        m_ph = 6;
`else
        m_ph = 0;
`endif
      end
      6: begin
`ifdef SEQ_STEP_EN
        if (step) m_ph = 0;
`endif
      end
      7: m_ph = 7;
      default: m_ph = m_ph + 1;
    endcase
  endtask

  task automatic check_all(input string tag);
    logic [5:0] exp_en;
    exp_en = (m_ph >= 0 && m_ph <= 5) ? 6'(1 << m_ph) : 6'd0;
    chk({tag, ".en"}, {58'd0, pc_en, w_en, m_en, e_en, d_en, f_en}, {58'd0, exp_en});
    chk({tag, ".run"}, {63'd0, running}, {63'd0, (m_ph >= 0 && m_ph <= 6)});
    chk({tag, ".stat"}, {61'd0, stat}, {61'd0, m_stat});
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".cnt"}, 64'(instr_count), 64'(m_cnt));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Advance n cycles with the current inputs, steering pc_new to pc+10.
  task automatic run(input int n, input string tag);
    repeat (n) begin
      pc_new = m_pc + 64'd10;
      cycle(tag);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_in();
    start = 1'b0; halt_in = 1'b0; imem_error = 1'b0;
    instr_invalid = 1'b0; dmem_error = 1'b0;
  endtask

  task automatic kick(input string tag);
    start = 1'b1;
    run(1, tag);
    start = 1'b0;
  endtask

  initial begin
    #2;
    // basic retire sequence: three instructions, pc steps by 10
    do_reset("rst0");
    kick("start");
    run(3 * INSTR_CYC, "seq");
    chk("seq_cnt", 64'(instr_count), 64'd3);
    chk("seq_pc", pc, RPC + 64'd30);

    // halt on the second fetch; start afterwards must not revive it
    do_reset("rst1");
    kick("start");
    run(INSTR_CYC, "pre_halt");
    halt_in = 1'b1;
    run(1, "halt");
    halt_in = 1'b0;
    chk("halt_stat", 64'(stat), 64'd2);
    chk("halt_pc", pc, RPC + 64'd10);
    chk("halt_cnt", 64'(instr_count), 64'd1);
    start = 1'b1;
    run(4, "halt_start");
    start = 1'b0;
    chk("halt_run", 64'(running), 64'd0);

    // fetch priority
    do_reset("rst2");
    kick("start");
    imem_error = 1'b1; instr_invalid = 1'b1; halt_in = 1'b1;
    run(1, "pri_all");
    clear_in();
    chk("pri_adr", 64'(stat), 64'd3);
    do_reset("rst3");
    kick("start");
    instr_invalid = 1'b1; halt_in = 1'b1;
    run(1, "pri_ins");
    clear_in();
    chk("pri_ins_stat", 64'(stat), 64'd4);

    // dmem_error ignored in EXECUTE, honoured in MEMORY
    do_reset("rst4");
    kick("start");
    run(2, "to_exec");
    dmem_error = 1'b1;
    run(1, "dm_exec");
    dmem_error = 1'b0;
    run(INSTR_CYC - 3, "dm_retire");
    chk("dm_cnt1", 64'(instr_count), 64'd1);
    run(3, "to_mem");
    dmem_error = 1'b1;
    run(1, "dm_mem");
    dmem_error = 1'b0;
    run(4, "dm_stop");
    chk("dm_stat", 64'(stat), 64'd3);
    chk("dm_pc", pc, RPC + 64'd10);

    // asynchronous reset in the middle of EXECUTE
    do_reset("rst5");
    kick("start");
    run(2, "to_exec2");
    #2;
    do_reset("async_rst");
    chk("async_pc", pc, RPC);

    // counter wrap
    kick("start");
    run((1 << CNT_W) * INSTR_CYC, "wrap");
    chk("wrap_cnt", 64'(instr_count), 64'd0);

`ifdef SEQ_STEP_EN
    // pause holds with step low, releases on a one-cycle step pulse
    do_reset("rst6");
    step = 1'b0;
    kick("start");
    run(6, "to_pause");
    run(5, "pause_hold");
    chk("pause_run", 64'(running), 64'd1);
    step = 1'b1;
    run(1, "step");
    step = 1'b0;
    chk("step_fen", 64'(f_en), 64'd1);
    step = 1'b1;
`endif

    // randomized phase
    do_reset("rst_rand");
    repeat (800) begin
      start         = ($urandom_range(0, 3) == 0);
      halt_in       = ($urandom_range(0, 11) == 0);
      imem_error    = ($urandom_range(0, 11) == 0);
      instr_invalid = ($urandom_range(0, 11) == 0);
      dmem_error    = ($urandom_range(0, 7) == 0);
      pc_new        = {$urandom, $urandom};
`ifdef SEQ_STEP_EN
      step          = ($urandom_range(0, 2) != 0);
`endif
      if ($urandom_range(0, 29) == 0) do_reset("rand_rst");
      else cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
